jk_bank_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared bank of JK flip-flop bits. Up to NREQ requesters each post one JK command (hold/clear/set/toggle) aimed at one bit of the bank. The block grants one requester at a time, applies the command with standard JK semantics, and acknowledges it. It sits between control agents and the status/flag bank, so no two agents ever drive the same flop in the same cycle.

---
 rtl/jk_bank_arbiter_if.sv | 25 ++
 rtl/jk_bank_arbiter.sv | 122 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bundle for the JK bank arbiter: per-requester
// command lanes in, one-hot ack and the bank contents out.
interface jk_bank_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    cmd;
    logic [IDXW*NREQ-1:0] idx;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic                 busy;
    logic [WIDTH-1:0]     q;

    modport master (
        output req, cmd, idx,
        input  ack, err, busy, q
    );

    modport slave (
        input  req, cmd, idx,
        output ack, err, busy, q
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that serialises JK commands from several
// requesters onto one shared bank of JK flip-flops.
module jk_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    jk_bank_arbiter_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state, state_next;
    logic [GW-1:0]    rr_ptr, rr_next;
    logic [GW-1:0]    grant, grant_next;
    logic [GW-1:0]    win;
    logic             found;
    int               pos;
    logic [1:0]       cmd_l, cmd_next, sel_cmd;
    logic [IDXW-1:0]  idx_l, idx_next, sel_idx;
    logic             sel_ok, lat_ok;
    logic [NREQ-1:0]  ack_r, ack_next;
    logic             err_r, err_next;
    logic             busy_r, busy_next;
    logic [WIDTH-1:0] q_r, q_next;

    // First pending request at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            if (!found && bus.req[pos]) begin
                found = 1'b1;
                win   = GW'(pos);
            end
        end
    end

    assign sel_cmd = bus.cmd[2*int'(win) +: 2];
    assign sel_idx = bus.idx[IDXW*int'(win) +: IDXW];
    assign sel_ok  = ({1'b0, sel_idx} < (IDXW+1)'(WIDTH));
    assign lat_ok  = ({1'b0, idx_l} < (IDXW+1)'(WIDTH));

    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        grant_next = grant;
        cmd_next   = cmd_l;
        idx_next   = idx_l;
        ack_next   = ack_r;
        err_next   = err_r;
        busy_next  = busy_r;
        q_next     = q_r;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_next    = win;
                    cmd_next      = sel_cmd;
                    idx_next      = sel_idx;
                    ack_next      = '0;
                    ack_next[win] = 1'b1;
                    err_next      = !sel_ok;
                    busy_next     = 1'b1;
                    state_next    = EXEC;
                end
            end
            EXEC: begin
                // Out-of-range targets are acknowledged but touch nothing.
                if (lat_ok) begin
                    unique case (cmd_l)
                        2'b01:   q_next[idx_l] = 1'b0;
                        2'b10:   q_next[idx_l] = 1'b1;
                        2'b11:   q_next[idx_l] = ~q_r[idx_l];
                        default: q_next[idx_l] = q_r[idx_l];
                    endcase
                end
                if (grant == GW'(NREQ - 1)) rr_next = '0;
                else                        rr_next = grant + GW'(1);
                ack_next   = '0;
                err_next   = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            cmd_l  <= '0;
            idx_l  <= '0;
            ack_r  <= '0;
            err_r  <= 1'b0;
            busy_r <= 1'b0;
            q_r    <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_next;
            grant  <= grant_next;
            cmd_l  <= cmd_next;
            idx_l  <= idx_next;
            ack_r  <= ack_next;
            err_r  <= err_next;
            busy_r <= busy_next;
            q_r    <= q_next;
        end
    end

    assign bus.ack  = ack_r;
    assign bus.err  = err_r;
    assign bus.busy = busy_r;
    assign bus.q    = q_r;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: expected grants are queued as
// stimulus is posted and checked when ack appears.
module tb_jk_bank_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jk_bank_arbiter_if #(.WIDTH(8), .NREQ(4)) if8 ();
    jk_bank_arbiter_if #(.WIDTH(6), .NREQ(4)) if6 ();

    jk_bank_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk(clk), .reset(reset), .bus(if8)
    );
    jk_bank_arbiter #(.WIDTH(6), .NREQ(4)) dut6 (
        .clk(clk), .reset(reset), .bus(if6)
    );

    typedef struct packed {
        logic [3:0] ack;
        logic       err;
        logic [7:0] q;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic sel6 = 1'b0;

    logic [3:0] ack_m;
    logic       err_m, busy_m;
    logic [7:0] q_m;

    always_comb begin
        ack_m  = sel6 ? if6.ack  : if8.ack;
        err_m  = sel6 ? if6.err  : if8.err;
        busy_m = sel6 ? if6.busy : if8.busy;
        q_m    = sel6 ? {2'b00, if6.q} : if8.q;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic post(input int r, input logic [1:0] c,
                        input logic [2:0] i);
        if (sel6) begin
            if6.req[r] = 1'b1;
            if6.cmd[2*r +: 2] = c;
            if6.idx[3*r +: 3] = i;
        end else begin
            if8.req[r] = 1'b1;
            if8.cmd[2*r +: 2] = c;
            if8.idx[3*r +: 3] = i;
        end
    endtask

    task automatic expect_grant(input logic [3:0] a, input logic e,
                                input logic [7:0] qv);
        exp_t x;
        x.ack = a;
        x.err = e;
        x.q   = qv;
        sb.push_back(x);
    endtask

    task automatic set_req(input logic [3:0] m, input bit on);
        if (sel6) if6.req = on ? (if6.req | m) : (if6.req & ~m);
        else      if8.req = on ? (if8.req | m) : (if8.req & ~m);
    endtask

    // Waits (bounded) for the next ack, checks it against the queue head,
    // drops the winner's req, then checks q once the command has landed.
    task automatic wait_ack(input string tag, input bit rearm,
                            input bit late);
        exp_t       e;
        int         n;
        logic [3:0] got;
        n = 0;
        @(negedge clk);
        while (ack_m == 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " ack"}, 32'(ack_m), 32'(e.ack));
            chk({tag, " err"}, 32'(err_m), 32'(e.err));
            chk({tag, " busy"}, 32'(busy_m), 32'd1);
            got = ack_m;
            set_req(got, 1'b0);
            if (late) begin
                if8.cmd = 8'hAA;
                if8.idx = 12'h924;
            end
            @(negedge clk);
            chk({tag, " ack_clr"}, 32'(ack_m), 32'd0);
            chk({tag, " busy_clr"}, 32'(busy_m), 32'd0);
            chk({tag, " q"}, 32'(q_m), 32'(e.q));
            if (rearm) set_req(got, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        if8.req = '0; if8.cmd = '0; if8.idx = '0;
        if6.req = '0; if6.cmd = '0; if6.idx = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst q", 32'(q_m), 32'd0);
        chk("rst ack", 32'(ack_m), 32'd0);
        chk("rst busy", 32'(busy_m), 32'd0);
        chk("rst err", 32'(err_m), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle q", 32'(q_m), 32'd0);
            chk("idle ack", 32'(ack_m), 32'd0);
            chk("idle busy", 32'(busy_m), 32'd0);
        end

        post(2, 2'b10, 3'd5);
        expect_grant(4'b0100, 1'b0, 8'h20);
        wait_ack("set5", 1'b0, 1'b0);
        post(2, 2'b01, 3'd5);
        expect_grant(4'b0100, 1'b0, 8'h00);
        wait_ack("clr5", 1'b0, 1'b0);

        post(0, 2'b10, 3'd7);
        expect_grant(4'b0001, 1'b0, 8'h80);
        wait_ack("set7", 1'b0, 1'b0);

        // Reset lands mid-EXEC: everything must clear before the next edge.
        post(1, 2'b10, 3'd1);
        @(negedge clk);
        chk("mid ack", 32'(ack_m), 32'b0010);
        reset = 1'b1;
        #1;
        chk("mid rst q", 32'(q_m), 32'd0);
        chk("mid rst ack", 32'(ack_m), 32'd0);
        chk("mid rst busy", 32'(busy_m), 32'd0);
        if8.req = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post rst q", 32'(q_m), 32'd0);

        for (int r = 0; r < 4; r++) post(r, 2'b11, 3'd0);
        expect_grant(4'b0001, 1'b0, 8'h01);
        expect_grant(4'b0010, 1'b0, 8'h00);
        expect_grant(4'b0100, 1'b0, 8'h01);
        expect_grant(4'b1000, 1'b0, 8'h00);
        expect_grant(4'b0001, 1'b0, 8'h01);
        for (int g = 0; g < 4; g++) wait_ack("rr", 1'b1, 1'b0);
        wait_ack("rr5", 1'b0, 1'b0);
        if8.req = '0;

        post(1, 2'b00, 3'd2);
        expect_grant(4'b0010, 1'b0, 8'h01);
        wait_ack("r1", 1'b0, 1'b0);
        post(1, 2'b10, 3'd2);
        post(3, 2'b10, 3'd3);
        expect_grant(4'b1000, 1'b0, 8'h09);
        expect_grant(4'b0010, 1'b0, 8'h0D);
        wait_ack("r3first", 1'b0, 1'b0);
        wait_ack("r1second", 1'b0, 1'b0);

        post(0, 2'b01, 3'd3);
        expect_grant(4'b0001, 1'b0, 8'h05);
        wait_ack("clr3", 1'b0, 1'b0);
        post(0, 2'b00, 3'd3);
        expect_grant(4'b0001, 1'b0, 8'h05);
        wait_ack("latched", 1'b0, 1'b1);

        sel6 = 1'b1;
        post(0, 2'b10, 3'd7);
        expect_grant(4'b0001, 1'b1, 8'h00);
        wait_ack("w6 idx7", 1'b0, 1'b0);
        post(0, 2'b10, 3'd5);
        expect_grant(4'b0001, 1'b0, 8'h20);
        wait_ack("w6 idx5", 1'b0, 1'b0);
        post(2, 2'b11, 3'd6);
        expect_grant(4'b0100, 1'b1, 8'h20);
        wait_ack("w6 idx6", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
